wbu: RTL and testbench

Load/store and write-back unit for the NPC core: the consumer end of the decoder's register-write interface. It accepts one executed instruction per handshake, performs any data-memory access through a request/response port, then drives the register-file write port (`w_regW`/`w_regAddr`/`w_regData`) and commits the next PC for fetch. It converts the single-cycle datapath into a multi-cycle one, with latency set by the memory.

---
 rtl/npc_pkg.sv | 25 ++
 rtl/lsu_align.sv | 65 ++++++
 rtl/wbu.sv | 233 +++++++++++++++++++++++
 tb/tb_wbu.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: constants and types shared by the NPC core back end.
//   - funct3 encodings for loads and stores
//   - wbu_state_t: write-back unit FSM states
package npc_pkg;

   // Load funct3 codes
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // Store funct3 codes (share the size field with the loads)
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      WB   = 2'd3
   } wbu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for 32-bit load/store accesses.
//   mem_op     in  3  : funct3 of the access
//   off        in  2  : byte offset inside the word (address[1:0])
//   store_data in  32 : rs2 value for stores
//   rdata      in  32 : word returned by memory for loads
//   misalign   out 1  : access does not fit its natural alignment
//   wstrb      out 4  : byte strobes for a store
//   wdata      out 32 : store data replicated onto the addressed lanes
//   load_data  out 32 : extracted and extended load result
module lsu_align
   import npc_pkg::*;
(
   input  logic [2:0]  mem_op,
   input  logic [1:0]  off,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic        misalign,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0]        shifted;
   logic signed [7:0]  ld_byte;
   logic signed [15:0] ld_half;

   always_comb begin
      shifted   = rdata >> {off, 3'b000};
      ld_byte   = shifted[7:0];
      ld_half   = shifted[15:0];
      misalign  = 1'b0;
      wstrb     = 4'b1111;
      wdata     = store_data;
      load_data = rdata;
      case (mem_op)
         LB: begin  // also SB
            wstrb     = 4'b0001 << off;
            wdata     = {4{store_data[7:0]}};
            load_data = 32'(ld_byte);
         end
         LH: begin  // also SH
            misalign  = off[0];
            wstrb     = 4'b0011 << off;
            wdata     = {2{store_data[15:0]}};
            load_data = 32'(ld_half);
         end
         LBU: begin
            wstrb     = 4'b0001 << off;
            wdata     = {4{store_data[7:0]}};
            load_data = {24'd0, shifted[7:0]};
         end
         LHU: begin
            misalign  = off[0];
            wstrb     = 4'b0011 << off;
            wdata     = {2{store_data[15:0]}};
            load_data = {16'd0, shifted[15:0]};
         end
         // LW/SW and every unlisted code behave as a full-word access
         default: begin
            misalign  = (off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/wbu.sv
// wbu: load/store and write-back unit of the NPC core.
// Accepts one executed instruction per handshake, runs an optional data
// memory access over a request/response port, then drives the register-file
// write port and commits the next PC for one cycle.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid / in_ready        : instruction handshake
//   in_aluRes .. in_dnpc       : executed instruction fields
//   mem_req_* / mem_rsp_*      : data-memory request/response port
//   w_regW/w_regAddr/w_regData : register-file write port (valid in WB)
//   commit_valid/commit_pc     : one-cycle commit pulse with next PC
//   misalign                   : one-cycle pulse at commit of a bad access
// Only DATA_WIDTH = 32 is supported.
module wbu
   import npc_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_aluRes,
   input  logic                  in_regW,
   input  logic [ADDR_WIDTH-1:0] in_regAddr,
   input  logic                  in_memR,
   input  logic                  in_memW,
   input  logic [2:0]            in_memOp,
   input  logic [DATA_WIDTH-1:0] in_storeData,
   input  logic [31:0]           in_dnpc,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_wen,
   output logic [31:0]           mem_req_addr,
   output logic [31:0]           mem_req_wdata,
   output logic [3:0]            mem_req_wstrb,
   input  logic                  mem_rsp_valid,
   input  logic [31:0]           mem_rsp_rdata,
   output logic                  mem_rsp_ready,
   output logic                  w_regW,
   output logic [ADDR_WIDTH-1:0] w_regAddr,
   output logic [DATA_WIDTH-1:0] w_regData,
   output logic                  commit_valid,
   output logic [31:0]           commit_pc,
   output logic                  misalign
);

   wbu_state_t state_q, state_d;

   // Captured instruction fields
   logic [DATA_WIDTH-1:0] alu_res_q, alu_res_d;
   logic                  reg_w_q, reg_w_d;
   logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic                  is_load_q, is_load_d;
   logic [2:0]            mem_op_q, mem_op_d;
   logic [31:0]           dnpc_q, dnpc_d;

   // Registered outputs
   logic                  in_ready_q, in_ready_d;
   logic                  mem_req_valid_q, mem_req_valid_d;
   logic                  mem_req_wen_q, mem_req_wen_d;
   logic [31:0]           mem_req_addr_q, mem_req_addr_d;
   logic [31:0]           mem_req_wdata_q, mem_req_wdata_d;
   logic [3:0]            mem_req_wstrb_q, mem_req_wstrb_d;
   logic                  mem_rsp_ready_q, mem_rsp_ready_d;
   logic                  w_reg_w_q, w_reg_w_d;
   logic [ADDR_WIDTH-1:0] w_reg_addr_q, w_reg_addr_d;
   logic [DATA_WIDTH-1:0] w_reg_data_q, w_reg_data_d;
   logic                  commit_valid_q, commit_valid_d;
   logic [31:0]           commit_pc_q, commit_pc_d;
   logic                  misalign_q, misalign_d;

   // One alignment block serves both ends of the access: in IDLE it looks at
   // the incoming instruction (alignment check, store encoding), afterwards
   // at the captured one (load extraction from the response).
   logic [2:0]  al_op;
   logic [1:0]  al_off;
   logic        al_misalign;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic [31:0] al_load;
   logic        in_is_mem;
   logic        in_bad;

   assign al_op     = (state_q == IDLE) ? in_memOp : mem_op_q;
   assign al_off    = (state_q == IDLE) ? in_aluRes[1:0] : alu_res_q[1:0];
   assign in_is_mem = in_memR | in_memW;
   assign in_bad    = in_is_mem & al_misalign;

   lsu_align u_align (
      .mem_op     (al_op),
      .off        (al_off),
      .store_data (in_storeData),
      .rdata      (mem_rsp_rdata),
      .misalign   (al_misalign),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   always_comb begin
      state_d         = state_q;
      alu_res_d       = alu_res_q;
      reg_w_d         = reg_w_q;
      reg_addr_d      = reg_addr_q;
      is_load_d       = is_load_q;
      mem_op_d        = mem_op_q;
      dnpc_d          = dnpc_q;
      mem_req_wen_d   = mem_req_wen_q;
      mem_req_addr_d  = mem_req_addr_q;
      mem_req_wdata_d = mem_req_wdata_q;
      mem_req_wstrb_d = mem_req_wstrb_q;
      w_reg_w_d       = 1'b0;
      w_reg_addr_d    = '0;
      w_reg_data_d    = '0;
      commit_valid_d  = 1'b0;
      commit_pc_d     = '0;
      misalign_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               alu_res_d  = in_aluRes;
               reg_w_d    = in_regW;
               reg_addr_d = in_regAddr;
               is_load_d  = in_memR;
               mem_op_d   = in_memOp;
               dnpc_d     = in_dnpc;
               if (in_is_mem && !al_misalign) begin
                  // A load wins when both memR and memW are set
                  state_d         = REQ;
                  mem_req_addr_d  = {in_aluRes[31:2], 2'b00};
                  mem_req_wen_d   = ~in_memR;
                  mem_req_wstrb_d = in_memR ? 4'b0000 : al_wstrb;
                  mem_req_wdata_d = in_memR ? 32'd0 : al_wdata;
               end else begin
                  state_d        = WB;
                  w_reg_w_d      = in_regW & (in_regAddr != '0) & ~in_bad;
                  w_reg_addr_d   = in_regAddr;
                  w_reg_data_d   = in_aluRes;
                  commit_valid_d = 1'b1;
                  commit_pc_d    = in_dnpc;
                  misalign_d     = in_bad;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) state_d = RESP;
         end
         RESP: begin
            if (mem_rsp_valid) begin
               state_d        = WB;
               w_reg_w_d      = reg_w_q & (reg_addr_q != '0);
               w_reg_addr_d   = reg_addr_q;
               w_reg_data_d   = is_load_q ? al_load : alu_res_q;
               commit_valid_d = 1'b1;
               commit_pc_d    = dnpc_q;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_d != REQ) begin
         mem_req_wen_d   = 1'b0;
         mem_req_addr_d  = '0;
         mem_req_wdata_d = '0;
         mem_req_wstrb_d = '0;
      end
      in_ready_d      = (state_d == IDLE);
      mem_req_valid_d = (state_d == REQ);
      mem_rsp_ready_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         in_ready_q      <= 1'b1;
         mem_req_valid_q <= 1'b0;
         mem_req_wen_q   <= 1'b0;
         mem_req_addr_q  <= '0;
         mem_req_wdata_q <= '0;
         mem_req_wstrb_q <= '0;
         mem_rsp_ready_q <= 1'b0;
         w_reg_w_q       <= 1'b0;
         w_reg_addr_q    <= '0;
         w_reg_data_q    <= '0;
         commit_valid_q  <= 1'b0;
         commit_pc_q     <= '0;
         misalign_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         in_ready_q      <= in_ready_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_wen_q   <= mem_req_wen_d;
         mem_req_addr_q  <= mem_req_addr_d;
         mem_req_wdata_q <= mem_req_wdata_d;
         mem_req_wstrb_q <= mem_req_wstrb_d;
         mem_rsp_ready_q <= mem_rsp_ready_d;
         w_reg_w_q       <= w_reg_w_d;
         w_reg_addr_q    <= w_reg_addr_d;
         w_reg_data_q    <= w_reg_data_d;
         commit_valid_q  <= commit_valid_d;
         commit_pc_q     <= commit_pc_d;
         misalign_q      <= misalign_d;
      end
   end

   // Captured fields are only read under FSM control, so they need no reset
   always_ff @(posedge clk) begin
      alu_res_q  <= alu_res_d;
      reg_w_q    <= reg_w_d;
      reg_addr_q <= reg_addr_d;
      is_load_q  <= is_load_d;
      mem_op_q   <= mem_op_d;
      dnpc_q     <= dnpc_d;
   end

   assign in_ready      = in_ready_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_wen   = mem_req_wen_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign mem_req_wdata = mem_req_wdata_q;
   assign mem_req_wstrb = mem_req_wstrb_q;
   assign mem_rsp_ready = mem_rsp_ready_q;
   assign w_regW        = w_reg_w_q;
   assign w_regAddr     = w_reg_addr_q;
   assign w_regData     = w_reg_data_q;
   assign commit_valid  = commit_valid_q;
   assign commit_pc     = commit_pc_q;
   assign misalign      = misalign_q;

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed bench for wbu. A driver task presents one instruction and
// plays the memory side with chosen wait counts; the expected transaction is
// computed from the access rules and a per-cycle compare process checks the
// DUT against it. Literal checks after each case pin the expectations.
module tb_wbu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_aluRes = '0;
   logic        in_regW = 1'b0;
   logic [4:0]  in_regAddr = '0;
   logic        in_memR = 1'b0;
   logic        in_memW = 1'b0;
   logic [2:0]  in_memOp = '0;
   logic [31:0] in_storeData = '0;
   logic [31:0] in_dnpc = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_wen;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;
   logic        mem_rsp_ready;
   logic        w_regW;
   logic [4:0]  w_regAddr;
   logic [31:0] w_regData;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        misalign;

   always #5 clk = ~clk;

   wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_aluRes(in_aluRes), .in_regW(in_regW), .in_regAddr(in_regAddr),
      .in_memR(in_memR), .in_memW(in_memW), .in_memOp(in_memOp),
      .in_storeData(in_storeData), .in_dnpc(in_dnpc),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .mem_rsp_ready(mem_rsp_ready),
      .w_regW(w_regW), .w_regAddr(w_regAddr), .w_regData(w_regData),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .misalign(misalign)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Expected transaction currently in flight
   bit          chk_en = 0;
   bit          active = 0;
   int          acc = 0;
   bit          e_mem, e_wen, e_w, e_mis, e_store;
   int          e_rw, e_sw;
   logic [31:0] e_addr, e_wdata, e_data, e_pc;
   logic [3:0]  e_wstrb;
   logic [4:0]  e_rd;

   // What the DUT showed, for the literal checks
   int          last_k, n_commit = 0;
   bit          req_seen;
   logic [31:0] last_data, last_addr, last_wdata, last_pc;
   logic [3:0]  last_wstrb;
   logic        last_w, last_mis, last_wen;

   function automatic int acc_size(input logic [2:0] op);
      case (op)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] op, input int off, input logic [31:0] rd);
      logic [31:0] s, r;
      s = rd >> (8 * off);
      case (op)
         3'b000: begin r = s & 32'hFF;   if (r >= 128)   r = r - 256;   end
         3'b001: begin r = s & 32'hFFFF; if (r >= 32768) r = r - 65536; end
         3'b100: r = s & 32'hFF;
         3'b101: r = s & 32'hFFFF;
         default: r = rd;
      endcase
      return r;
   endfunction

   always @(negedge clk) begin : cmp
      int k, ck;
      bit reqv, rspr, cm;
      k = -1; reqv = 0; rspr = 0; cm = 0;
      if (chk_en) begin
         if (active) begin
            k    = cyc - acc + 1;
            ck   = e_mem ? 3 + e_rw + e_sw : 1;
            reqv = e_mem && (k <= 1 + e_rw);
            rspr = e_mem && (k >= 2 + e_rw) && (k <= 2 + e_rw + e_sw);
            cm   = (k == ck);
         end
         check("in_ready", in_ready, !active);
         check("mem_req_valid", mem_req_valid, reqv);
         check("mem_rsp_ready", mem_rsp_ready, rspr);
         check("commit_valid", commit_valid, cm);
         check("misalign", misalign, cm && e_mis);
         check("w_regW", w_regW, cm && e_w);
         if (reqv) begin
            check("req_addr", mem_req_addr, e_addr);
            check("req_wen", mem_req_wen, e_wen);
            check("req_wstrb", mem_req_wstrb, e_wstrb);
            if (e_store) check("req_wdata", mem_req_wdata, e_wdata);
         end
         if (cm) begin
            check("commit_pc", commit_pc, e_pc);
            check("w_regAddr", w_regAddr, e_rd);
            if (e_w) check("w_regData", w_regData, e_data);
         end
         if (mem_req_valid) begin
            req_seen   = 1;
            last_addr  = mem_req_addr;
            last_wen   = mem_req_wen;
            last_wstrb = mem_req_wstrb;
            last_wdata = mem_req_wdata;
         end
         if (commit_valid) begin
            n_commit++;
            last_k    = k;
            last_w    = w_regW;
            last_data = w_regData;
            last_pc   = commit_pc;
            last_mis  = misalign;
         end
      end
   end

   // Fill in the expectation for one instruction from the access rules
   task automatic set_expect(input logic mr, input logic mw, input logic [2:0] op,
                             input logic [31:0] alu, input logic [31:0] sd, input logic rwe,
                             input logic [4:0] rd, input logic [31:0] pc, input int rqw,
                             input int rsw, input logic [31:0] rdata);
      int sz, off, m;
      bit memop;
      memop   = mr | mw;
      sz      = acc_size(op);
      off     = int'(alu[1:0]);
      e_mis   = memop && ((off % sz) != 0);
      e_mem   = memop && !e_mis;
      e_store = mw && !mr;
      e_rw    = rqw;
      e_sw    = rsw;
      e_addr  = alu - off;
      e_wen   = !mr;
      m       = ((1 << sz) - 1) << off;
      e_wstrb = mr ? 4'd0 : m[3:0];
      if (sz == 1)      e_wdata = (sd & 32'hFF) * 32'h01010101;
      else if (sz == 2) e_wdata = (sd & 32'hFFFF) * 32'h00010001;
      else              e_wdata = sd;
      e_w     = rwe && (rd != 0) && !e_mis;
      e_rd    = rd;
      e_pc    = pc;
      e_data  = (mr && !e_mis) ? exp_load(op, off, rdata) : alu;
   endtask

   task automatic present(input logic mr, input logic mw, input logic [2:0] op,
                          input logic [31:0] alu, input logic [31:0] sd, input logic rwe,
                          input logic [4:0] rd, input logic [31:0] pc);
      req_seen     = 0;
      last_k       = -1;
      in_valid     = 1;
      in_memR      = mr;
      in_memW      = mw;
      in_memOp     = op;
      in_aluRes    = alu;
      in_storeData = sd;
      in_regW      = rwe;
      in_regAddr   = rd;
      in_dnpc      = pc;
      @(posedge clk); #1;
      acc      = cyc;
      active   = 1;
      // Captured fields must not follow the inputs after the handshake
      in_valid     = 0;
      in_memR      = 1'($urandom);
      in_memW      = 1'($urandom);
      in_memOp     = 3'($urandom);
      in_aluRes    = $urandom;
      in_storeData = $urandom;
      in_regW      = 1'($urandom);
      in_regAddr   = 5'($urandom);
      in_dnpc      = $urandom;
   endtask

   task automatic do_op(input logic mr, input logic mw, input logic [2:0] op,
                        input logic [31:0] alu, input logic [31:0] sd, input logic rwe,
                        input logic [4:0] rd, input logic [31:0] pc, input int rqw,
                        input int rsw, input logic [31:0] rdata, input bit early);
      set_expect(mr, mw, op, alu, sd, rwe, rd, pc, rqw, rsw, rdata);
      present(mr, mw, op, alu, sd, rwe, rd, pc);
      if (e_mem) begin
         for (int k = 1; k <= 1 + rqw; k++) begin
            mem_req_ready = (k == 1 + rqw);
            mem_rsp_valid = early && (k == 1 + rqw);
            mem_rsp_rdata = $urandom;
            @(posedge clk); #1;
         end
         mem_req_ready = 0;
         for (int k = 0; k <= rsw; k++) begin
            mem_rsp_valid = (k == rsw);
            mem_rsp_rdata = (k == rsw) ? rdata : $urandom;
            @(posedge clk); #1;
         end
         mem_rsp_valid = 0;
      end
      @(posedge clk); #1;
      active = 0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int nc;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      check("rst_in_ready", in_ready, 1);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_wen", mem_req_wen, 0);
      check("rst_req_addr", mem_req_addr, 0);
      check("rst_req_wdata", mem_req_wdata, 0);
      check("rst_req_wstrb", mem_req_wstrb, 0);
      check("rst_rsp_ready", mem_rsp_ready, 0);
      check("rst_w_regW", w_regW, 0);
      check("rst_w_regAddr", w_regAddr, 0);
      check("rst_w_regData", w_regData, 0);
      check("rst_commit", commit_valid, 0);
      check("rst_commit_pc", commit_pc, 0);
      check("rst_misalign", misalign, 0);
      chk_en = 1;

      // ALU op
      do_op(0, 0, 3'b000, 32'h0000002A, 0, 1, 5'd5, 32'h80000004, 0, 0, 0, 0);
      check("alu_lat", last_k, 1);
      check("alu_w", last_w, 1);
      check("alu_data", last_data, 32'h0000002A);
      check("alu_pc", last_pc, 32'h80000004);

      // LB / LBU
      do_op(1, 0, 3'b000, 32'h80000103, 0, 1, 5'd7, 32'h80000008, 0, 0, 32'h80FF1122, 0);
      check("lb_addr", last_addr, 32'h80000100);
      check("lb_wen", last_wen, 0);
      check("lb_data", last_data, 32'hFFFFFF80);
      check("lb_lat", last_k, 3);
      do_op(1, 0, 3'b100, 32'h80000103, 0, 1, 5'd7, 32'h8000000C, 0, 0, 32'h80FF1122, 0);
      check("lbu_data", last_data, 32'h00000080);

      // SH
      do_op(0, 1, 3'b001, 32'h80000202, 32'h0000BEEF, 0, 5'd9, 32'h80000010, 0, 0, 0, 0);
      check("sh_wstrb", last_wstrb, 4'b1100);
      check("sh_wdata", last_wdata, 32'hBEEFBEEF);
      check("sh_wen", last_wen, 1);
      check("sh_w", last_w, 0);

      // Back-pressure on both channels
      do_op(1, 0, 3'b010, 32'h80000010, 0, 1, 5'd3, 32'h80000014, 3, 1, 32'hDEADBEEF, 0);
      check("bp_lat", last_k, 7);
      check("bp_data", last_data, 32'hDEADBEEF);

      // Misaligned LW and write to x0
      do_op(1, 0, 3'b010, 32'h80000002, 0, 1, 5'd4, 32'h80000018, 0, 0, 0, 0);
      check("mis_noreq", req_seen, 0);
      check("mis_pulse", last_mis, 1);
      check("mis_w", last_w, 0);
      check("mis_lat", last_k, 1);
      do_op(0, 0, 3'b000, 32'h00000055, 0, 1, 5'd0, 32'h8000001C, 0, 0, 0, 0);
      check("x0_w", last_w, 0);

      // Further access shapes
      do_op(1, 0, 3'b001, 32'h80000402, 0, 1, 5'd10, 32'h80000020, 1, 2, 32'h80017FFF, 0);
      check("lh_data", last_data, 32'hFFFF8001);
      do_op(1, 0, 3'b101, 32'h80000402, 0, 1, 5'd11, 32'h80000024, 0, 0, 32'h80017FFF, 0);
      check("lhu_data", last_data, 32'h00008001);
      do_op(0, 1, 3'b000, 32'h80000501, 32'h12345678, 0, 5'd0, 32'h80000028, 2, 0, 0, 0);
      check("sb_wstrb", last_wstrb, 4'b0010);
      check("sb_wdata", last_wdata, 32'h78787878);
      do_op(0, 1, 3'b010, 32'h80000600, 32'hCAFEF00D, 0, 5'd0, 32'h8000002C, 0, 1, 0, 0);
      do_op(1, 0, 3'b001, 32'h80000703, 0, 1, 5'd12, 32'h80000030, 0, 0, 0, 0);
      do_op(0, 1, 3'b001, 32'h80000701, 32'h1111, 0, 5'd0, 32'h80000034, 0, 0, 0, 0);
      check("shmis_noreq", req_seen, 0);
      do_op(1, 1, 3'b010, 32'h80000800, 32'h99999999, 1, 5'd13, 32'h80000038, 0, 0, 32'h0BADF00D, 0);
      check("rw_wen", last_wen, 0);
      do_op(1, 0, 3'b011, 32'h80000904, 0, 1, 5'd14, 32'h8000003C, 0, 0, 32'h01234567, 0);
      check("op011_data", last_data, 32'h01234567);
      // Response offered while still in REQ must be ignored
      do_op(1, 0, 3'b010, 32'h80000A00, 0, 1, 5'd15, 32'h80000040, 1, 0, 32'h5A5A5A5A, 1);
      check("early_data", last_data, 32'h5A5A5A5A);
      check("early_lat", last_k, 4);

      // Reset in RESP, then a stray late response
      nc = n_commit;
      set_expect(1, 0, 3'b010, 32'h80000B00, 0, 1, 5'd16, 32'h80000044, 0, 5, 0);
      present(1, 0, 3'b010, 32'h80000B00, 0, 1, 5'd16, 32'h80000044);
      mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      active = 0;
      mem_rsp_valid = 1;
      mem_rsp_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      mem_rsp_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid_commit", n_commit, nc);
      check("rst_mid_ready", in_ready, 1);

      // Unit keeps working after the reset
      do_op(0, 0, 3'b000, 32'h00001234, 0, 1, 5'd17, 32'h80000048, 0, 0, 0, 0);
      check("post_rst_data", last_data, 32'h00001234);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
